cj: RTL and testbench
=====================

# cj

Co-simulation end-of-test monitor for the fuzzing bench. It snoops the memory write path for stores to the HTIF `tohost` doubleword and holds the merged 64-bit value on `tohost`; bit 0 set means the test has finished. It counts cycles since reset and, when configured, forces a timeout code if the program never signals completion. It sits beside the SoC harness; the bench polls `tohost` every cycle.

## Interface
- `ADDR_W`, 32: width of the snooped write address.
- `TOHOST_ADDR`, 32'h8000_1000: byte address of `tohost`, 8-byte aligned.
- `TIMEOUT_CYCLES`, 64'd2_000_000_000: cycle budget before a forced timeout.
- `TIMEOUT_CODE`, 64'd5: value forced into `tohost` on timeout (done, exit code 2).
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `wr_valid`  in  1  a memory write is presented this cycle.
- `wr_addr`  in  ADDR_W  byte address of the write.
- `wr_data`  in  64  write data, doubleword-aligned lanes.
- `wr_mask`  in  8  byte enables; bit i enables `wr_data[8i+7:8i]`.
- `tohost`  out  64  captured `tohost` value.
- `done`  out  1  equals `tohost[0]`.
- `exit_code`  out  63  equals `tohost[63:1]`.
- `cycle_count`  out  64  cycles elapsed since reset was released.
- `timeout`  out  1  set when the timeout code was forced.

## Operation
- Hit: `wr_valid && wr_addr[ADDR_W-1:3] == TOHOST_ADDR[ADDR_W-1:3]`. `wr_addr[2:0]` is ignored.
- On a hit while `done==0`, each byte with its `wr_mask` bit set replaces the corresponding byte of `tohost`. Unmasked bytes keep their value. A mask of 0 changes nothing.
- Writes with bit 0 clear are accepted and update `tohost`; `done` stays 0.
- Once `done==1`, `tohost` is sticky. All further hits are ignored until reset.
- `cycle_count` increments by 1 every cycle while `done==0`, holds once `done==1`, and saturates at all-ones.
- Timeout (macro enabled only):
  - Condition: `done==0`, no hit this cycle, and `cycle_count == TIMEOUT_CYCLES-1`.
  - Action: `tohost <= TIMEOUT_CODE` and `timeout <= 1`.
- If a hit and the timeout condition occur in the same cycle, the hit wins and the timeout is skipped.
- Writes to any other address are ignored.

## Timing
- All state is registered on the rising edge of `clock`.
- Reset (`reset==0`, sampled at the edge) clears `tohost`, `cycle_count` and `timeout` to 0. `done` and `exit_code` therefore also read 0.
- Reset asserted mid-test discards all state on that edge; hits arriving during reset are dropped.
- A hit in cycle N is visible on `tohost`, `done` and `exit_code` after edge N+1, so latency is 1 cycle.
- `done` and `exit_code` are pure combinational slices of the `tohost` register.
- The first cycle after reset release reads `cycle_count==0`.

## Configuration
- `CJ_TIMEOUT_EN` defined: the timeout watchdog is compiled in as described above.
- `CJ_TIMEOUT_EN` undefined:
  - No watchdog logic is built.
  - `timeout` is tied to 0 and `tohost` changes only on hits.
  - `cycle_count` still counts.

## Structure
- Package `cj_pkg` holds:
  - default `TOHOST_ADDR`, `TIMEOUT_CYCLES` and `TIMEOUT_CODE` constants;
  - the HTIF done bit index;
  - a `merge_bytes(old, data, mask)` function.
- One sub-module, `cj_watchdog`: the cycle counter plus the timeout compare. It is instantiated only under `CJ_TIMEOUT_EN`; otherwise a bare counter is used.

## Test plan
- Reset, then hit at 0x8000_1000 with data 0x1 and mask 0xFF -> next cycle `tohost==1`, `done==1`, `exit_code==0`.
- Hit with data 0x0000_0000_0000_0007, then a second hit with data 0x3 -> `tohost==7`, `exit_code==3`, and the second write is ignored.
- Hit at 0x8000_1004 with data 0xAABB_CCDD_0000_0000 and mask 0xF0 -> `tohost==0xAABB_CCDD_0000_0000`, `done==0`.
- Hit at 0x8000_1008 with data 0x1 and mask 0xFF -> `tohost` stays 0.
- With `CJ_TIMEOUT_EN` and `TIMEOUT_CYCLES=100`, no writes -> at `cycle_count==100`, `tohost==5` and `timeout==1`.
  - Repeat with a hit of data 0x1 in the cycle where `cycle_count==99` -> `tohost==1` and `timeout==0`.
- Assert reset after `done==1` -> `tohost`, `cycle_count` and `timeout` all return to 0 and counting restarts.

Source files
------------

// File: rtl/cj_pkg.sv
// Shared constants and the byte-merge helper for the cj tohost monitor.
// The optional watchdog is selected by the CJ_TIMEOUT_EN macro in cj.sv.
package cj_pkg;

  localparam logic [31:0] DEF_TOHOST_ADDR    = 32'h8000_1000;
  localparam logic [63:0] DEF_TIMEOUT_CYCLES = 64'd2_000_000_000;
  localparam logic [63:0] DEF_TIMEOUT_CODE   = 64'd5;
  localparam int          DONE_BIT           = 0;

  // Byte i of the result comes from data when mask[i] is set, else from old_val.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] data,
                                              input logic [7:0]  mask);
    logic [63:0] merged;
    merged = old_val;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) merged[8*i +: 8] = data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/cj_watchdog.sv
// Cycle counter with the timeout compare; fire requests the forced timeout code.
// Counting stops once the test is done and saturates at all-ones.
module cj_watchdog
  import cj_pkg::*;
#(
  parameter logic [63:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        done,
  input  logic        hit,
  output logic [63:0] cycle_count,
  output logic        fire
);

  logic [63:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else if (!done && (count_q != '1)) begin
      count_q <= count_q + 64'd1;
    end
  end

  // A hit in the same cycle takes priority, so the timeout is skipped.
  assign fire        = !done && !hit && (count_q == TIMEOUT_CYCLES - 64'd1);
  assign cycle_count = count_q;

endmodule

// File: rtl/cj.sv
// End-of-test monitor: snoops stores to the HTIF tohost doubleword.
// Define CJ_TIMEOUT_EN to build the timeout watchdog (cj_watchdog).
module cj
  import cj_pkg::*;
#(
  parameter int                 ADDR_W         = 32,
  parameter logic [ADDR_W-1:0]  TOHOST_ADDR    = ADDR_W'(DEF_TOHOST_ADDR),
  parameter logic [63:0]        TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [63:0]        TIMEOUT_CODE   = DEF_TIMEOUT_CODE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [63:0]       wr_data,
  input  logic [7:0]        wr_mask,
  output logic [63:0]       tohost,
  output logic              done,
  output logic [62:0]       exit_code,
  output logic [63:0]       cycle_count,
  output logic              timeout
);

  // The write port is snoop-only: wr_valid qualifies wr_addr/wr_data/wr_mask
  // in the cycle it is high and there is no ready; every write is observed.
  logic [63:0] tohost_q;
  logic        hit;
  logic        fire;

  assign hit       = wr_valid && (wr_addr[ADDR_W-1:3] == TOHOST_ADDR[ADDR_W-1:3]);
  assign tohost    = tohost_q;
  assign done      = tohost_q[DONE_BIT];
  assign exit_code = tohost_q[63:1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      tohost_q <= '0;
    end else if (!done) begin
      if (hit) begin
        tohost_q <= merge_bytes(tohost_q, wr_data, wr_mask);
      end else if (fire) begin
        tohost_q <= TIMEOUT_CODE;
      end
    end
  end

`ifdef CJ_TIMEOUT_EN
  logic timeout_q;

  cj_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock      (clock),
    .reset      (reset),
    .done       (done),
    .hit        (hit),
    .cycle_count(cycle_count),
    .fire       (fire)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      timeout_q <= 1'b0;
    end else if (fire) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  logic [63:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else if (!done && (count_q != '1)) begin
      count_q <= count_q + 64'd1;
    end
  end

  assign cycle_count = count_q;
  assign fire        = 1'b0;
  assign timeout     = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  logic unused_addr;
  assign unused_addr = ^wr_addr[2:0];

endmodule

// File: tb/tb_cj.sv
// Directed bench for cj: byte merge, sticky done, address decode, counter,
// reset, and (with CJ_TIMEOUT_EN) the forced timeout and its hit override.
module tb_cj;

  localparam logic [63:0] TB_TIMEOUT = 64'd100;

  logic        clock;
  logic        reset;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_mask;
  logic [63:0] tohost;
  logic        done;
  logic [62:0] exit_code;
  logic [63:0] cycle_count;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [63:0] model_tohost;

  cj #(
    .ADDR_W        (32),
    .TOHOST_ADDR   (32'h8000_1000),
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .TIMEOUT_CODE  (64'd5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask),
    .tohost     (tohost),
    .done       (done),
    .exit_code  (exit_code),
    .cycle_count(cycle_count),
    .timeout    (timeout)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL time_limit obs=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=0x%h exp=0x%h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset    = 1'b0;
    wr_valid = 1'b0;
    @(posedge clock);
    #1;
    reset        = 1'b1;
    model_tohost = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // driver: presents one write for one cycle and scores tohost afterwards
  task automatic drive_write(input logic [31:0] addr, input logic [63:0] data,
                             input logic [7:0] mask, input logic valid, input string tag);
    logic [31:0] base;
    base     = 32'h8000_1000;
    wr_valid = valid;
    wr_addr  = addr;
    wr_data  = data;
    wr_mask  = mask;
    if (valid && (addr[31:3] == base[31:3]) && !model_tohost[0]) begin
      for (int i = 0; i < 8; i++) begin
        if (mask[i]) model_tohost[8*i +: 8] = data[8*i +: 8];
      end
    end
    exp_q.push_back(model_tohost);
    @(posedge clock);
    #1;
    wr_valid = 1'b0;
    check(tag, tohost, exp_q.pop_front());
  endtask

  initial begin
    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_mask  = '0;
    model_tohost = '0;
    @(posedge clock);
    #1;
    apply_reset();

    check("reset_tohost", tohost, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_exit", {1'b0, exit_code}, 64'd0);
    check("reset_count", cycle_count, 64'd0);
    check("reset_timeout", {63'd0, timeout}, 64'd0);
    idle(3);
    check("count_3", cycle_count, 64'd3);

    drive_write(32'h8000_1000, 64'h1, 8'hFF, 1'b1, "pass_write");
    check("pass_done", {63'd0, done}, 64'd1);
    check("pass_exit", {1'b0, exit_code}, 64'd0);
    idle(2);
    check("count_hold_done", cycle_count, 64'd4);
    drive_write(32'h8000_1000, 64'h3, 8'hFF, 1'b1, "sticky_after_pass");

    apply_reset();
    drive_write(32'h8000_1000, 64'h7, 8'hFF, 1'b1, "exit3_write");
    check("exit3_code", {1'b0, exit_code}, 64'd3);
    check("exit3_done", {63'd0, done}, 64'd1);
    drive_write(32'h8000_1000, 64'h3, 8'hFF, 1'b1, "exit3_sticky");

    apply_reset();
    drive_write(32'h8000_1004, 64'hAABB_CCDD_0000_0000, 8'hF0, 1'b1, "upper_lanes");
    check("upper_not_done", {63'd0, done}, 64'd0);
    drive_write(32'h8000_1000, 64'h0000_0000_0000_EE00, 8'h02, 1'b1, "byte1_merge");
    drive_write(32'h8000_1000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1, "mask_zero");
    drive_write(32'h8000_1000, 64'h1, 8'hFF, 1'b0, "valid_low");
    drive_write(32'h0000_1000, 64'h1, 8'hFF, 1'b1, "upper_addr_miss");
    drive_write(32'h8000_1008, 64'h1, 8'hFF, 1'b1, "next_dword_miss");
    check("count_not_done", cycle_count, 64'd6);
    drive_write(32'h8000_1007, 64'h1, 8'h01, 1'b1, "low_addr_ignored");
    check("low_addr_done", {63'd0, done}, 64'd1);

`ifdef CJ_TIMEOUT_EN
    apply_reset();
    idle(99);
    check("pre_timeout_count", cycle_count, 64'd99);
    check("pre_timeout_tohost", tohost, 64'd0);
    check("pre_timeout_flag", {63'd0, timeout}, 64'd0);
    idle(1);
    check("timeout_count", cycle_count, 64'd100);
    check("timeout_tohost", tohost, 64'd5);
    check("timeout_flag", {63'd0, timeout}, 64'd1);
    check("timeout_exit", {1'b0, exit_code}, 64'd2);
    model_tohost = 64'd5;
    idle(3);
    check("timeout_count_hold", cycle_count, 64'd100);

    apply_reset();
    idle(99);
    drive_write(32'h8000_1000, 64'h1, 8'hFF, 1'b1, "hit_beats_timeout");
    check("hit_beats_timeout_flag", {63'd0, timeout}, 64'd0);
    check("hit_beats_timeout_count", cycle_count, 64'd100);
`else
    apply_reset();
    idle(150);
    check("no_wd_count", cycle_count, 64'd150);
    check("no_wd_tohost", tohost, 64'd0);
    check("no_wd_flag", {63'd0, timeout}, 64'd0);
`endif

    drive_write(32'h8000_1000, 64'h1, 8'hFF, 1'b1, "final_done");
    check("final_done_bit", {63'd0, done}, 64'd1);
    apply_reset();
    check("rereset_tohost", tohost, 64'd0);
    check("rereset_count", cycle_count, 64'd0);
    check("rereset_timeout", {63'd0, timeout}, 64'd0);
    idle(2);
    check("rereset_counting", cycle_count, 64'd2);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain obs=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
